data_memory_unit: RTL and testbench

Word-organised data RAM with a request/stall handshake, sitting directly downstream of the memory stage. It consumes the stage's access request (enable, read/write, address, store data, store size) and returns the aligned 32-bit read word that the memory stage sign- or zero-extends. A configurable access latency and a stall output let the pipeline hold the request until the access completes. Sub-word stores are committed by byte lane; misaligned or out-of-range accesses are flagged.

---
 rtl/data_memory_unit.sv | 126 ++++++++++++
 tb/tb_data_memory_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// Word-organised data RAM behind the memory stage: request/stall handshake,
// configurable wait latency, byte-lane stores and misalign/range fault flagging.
module data_memory_unit #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_enable,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic [1:0]  store_size,
    output logic [31:0] mem_data_out,
    output logic        stall,
    output logic        fault
);
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  LAT4 = 4'(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;

    logic [31:0] mem [DEPTH];

    logic [31:0] offset;
    logic [AW-1:0] idx;
    logic        in_range;
    logic        aligned;
    logic [3:0]  lane_en;
    logic [31:0] wdata;
    logic [31:0] rdata;

    // Decode of the latched request; only meaningful in ACCESS.
    always_comb begin
        offset   = req_addr - BASE_ADDR;
        in_range = (req_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
        idx      = offset[AW+1:2];
        rdata    = mem[idx];
        aligned  = 1'b1;
        lane_en  = 4'b1111;
        wdata    = req_data;
        case (req_size)
            2'b00: begin
                lane_en = 4'b0001 << req_addr[1:0];
                wdata   = {4{req_data[7:0]}};
            end
            2'b01: begin
                aligned = ~req_addr[0];
                lane_en = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{req_data[15:0]}};
            end
            default: aligned = (req_addr[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                stall = mem_enable;
                if (mem_enable) begin
                    cnt_nxt   = LAT4;
                    state_nxt = (LATENCY > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                stall   = 1'b1;
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                stall     = 1'b1;
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            req_write    <= 1'b0;
            req_addr     <= '0;
            req_data     <= '0;
            req_size     <= '0;
            mem_data_out <= '0;
            fault        <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && mem_enable) begin
                req_write <= mem_write;
                req_addr  <= address;
                req_data  <= data_in;
                req_size  <= store_size;
            end
            if (state == S_ACCESS) begin
                mem_data_out <= (!req_write && in_range) ? rdata : '0;
                fault        <= req_write ? !(in_range && aligned) : !in_range;
            end else if (state == S_DONE) begin
                fault <= 1'b0;
            end
        end
    end

    // Array is deliberately not reset; an aborted store never reaches ACCESS.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && req_write && in_range && aligned) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (lane_en[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: three builds (LATENCY 1, 0, 3) share clock and reset.
module tb_data_memory_unit;
    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        flt;
    } exp_t;

    exp_t exp_q[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    logic        en   [3];
    logic        wr   [3];
    logic [31:0] addr [3];
    logic [31:0] din  [3];
    logic [1:0]  size [3];
    logic [31:0] dout [3];
    logic        stall[3];
    logic        flt  [3];

    int  timeouts = 0;
    bit  tb_done  = 1'b0;
    int  n_checks = 0;
    int  n_fails  = 0;

    // Instance 0: LATENCY=1, instance 1: LATENCY=0, instance 2: LATENCY=3.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_memory_unit #(
            .DEPTH    (1024),
            .LATENCY  (g == 0 ? 1 : (g == 1 ? 0 : 3)),
            .BASE_ADDR(32'h0000_0000)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .mem_enable  (en[g]),
            .mem_write   (wr[g]),
            .address     (addr[g]),
            .data_in     (din[g]),
            .store_size  (size[g]),
            .mem_data_out(dout[g]),
            .stall       (stall[g]),
            .fault       (flt[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    // Monitor: DONE is the cycle where stall falls after a stalled run.
    logic prev_stall[3];
    int   run[3];

    always @(negedge clk) begin : mon
        exp_t e;
        bit   done;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (stall[i] !== 1'b0 || dout[i] !== 32'h0 || flt[i] !== 1'b0) begin
                    n_fails++;
                    $display("FAIL reset_state dut%0d: stall=%b data=%h fault=%b, required 0/00000000/0",
                             i, stall[i], dout[i], flt[i]);
                end
                prev_stall[i] <= 1'b0;
                run[i]        <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                done = prev_stall[i] && !stall[i];
                if (done) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fails++;
                        $display("FAIL unexpected_response dut%0d: data=%h fault=%b, required no response",
                                 i, dout[i], flt[i]);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.dut != i) begin
                            n_fails++;
                            $display("FAIL response_source: got dut%0d, required dut%0d", i, e.dut);
                        end
                        n_checks++;
                        if (dout[i] !== e.data) begin
                            n_fails++;
                            $display("FAIL read_data dut%0d: got %h, required %h", i, dout[i], e.data);
                        end
                        n_checks++;
                        if (flt[i] !== e.flt) begin
                            n_fails++;
                            $display("FAIL fault_flag dut%0d: got %b, required %b", i, flt[i], e.flt);
                        end
                        n_checks++;
                        if (run[i] != lat_of(i) + 2) begin
                            n_fails++;
                            $display("FAIL stall_length dut%0d: got %0d cycles, required %0d",
                                     i, run[i], lat_of(i) + 2);
                        end
                    end
                end else begin
                    n_checks++;
                    if (flt[i] !== 1'b0) begin
                        n_fails++;
                        $display("FAIL fault_outside_done dut%0d: got %b, required 0", i, flt[i]);
                    end
                end
                prev_stall[i] <= stall[i];
                run[i]        <= stall[i] ? run[i] + 1 : 0;
            end
        end
        if (tb_done) begin
            n_checks++;
            if (timeouts != 0) begin
                n_fails++;
                $display("FAIL handshake_timeout: got %0d timeouts, required 0", timeouts);
            end
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fails++;
                $display("FAIL pending_responses: got %0d outstanding, required 0", exp_q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
            $finish;
        end
    end

    task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] data,
                         input logic [1:0] sz, input logic [31:0] ed, input logic ef);
        exp_t e;
        bit   seen;
        e.dut = d;
        e.data = ed;
        e.flt = ef;
        exp_q.push_back(e);
        @(posedge clk); #1;
        en[d] = 1'b1; wr[d] = w; addr[d] = a; din[d] = data; size[d] = sz;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (!stall[d]) seen = 1'b1;
        end
        if (!seen) timeouts++;
        en[d] = 1'b0;
    endtask

    task automatic st(input int d, input logic [31:0] a, input logic [31:0] data,
                      input logic [1:0] sz, input logic ef);
        issue(d, 1'b1, a, data, sz, 32'h0, ef);
    endtask

    task automatic ld(input int d, input logic [31:0] a, input logic [31:0] ed, input logic ef);
        issue(d, 1'b0, a, 32'h0, 2'b10, ed, ef);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; din[i] = '0; size[i] = '0;
        end
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;

        // LATENCY=1: word/byte/half stores, loads, alignment and range faults.
        st(0, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
        ld(0, 32'h10, 32'hDEADBEEF, 1'b0);
        st(0, 32'h20, 32'h11223344, 2'b10, 1'b0);
        st(0, 32'h22, 32'h000000AA, 2'b00, 1'b0);
        ld(0, 32'h20, 32'h11AA3344, 1'b0);
        ld(0, 32'h23, 32'h11AA3344, 1'b0);
        st(0, 32'h24, 32'h11223344, 2'b10, 1'b0);
        st(0, 32'h26, 32'h0000BEEF, 2'b01, 1'b0);
        ld(0, 32'h24, 32'hBEEF3344, 1'b0);
        st(0, 32'h25, 32'h00001234, 2'b01, 1'b1);
        ld(0, 32'h24, 32'hBEEF3344, 1'b0);
        st(0, 32'h11, 32'hFFFFFF77, 2'b00, 1'b0);
        ld(0, 32'h10, 32'hDEAD77EF, 1'b0);
        st(0, 32'h12, 32'h99999999, 2'b10, 1'b1);
        ld(0, 32'h10, 32'hDEAD77EF, 1'b0);
        st(0, 32'h14, 32'h01020304, 2'b11, 1'b0);
        st(0, 32'h16, 32'hFFFFFFFF, 2'b11, 1'b1);
        ld(0, 32'h14, 32'h01020304, 1'b0);
        st(0, 32'h00, 32'hA5A5A5A5, 2'b10, 1'b0);
        st(0, 32'hFFC, 32'h0BADF00D, 2'b10, 1'b0);
        ld(0, 32'h1000, 32'h00000000, 1'b1);
        st(0, 32'h1000, 32'hFFFFFFFF, 2'b10, 1'b1);
        ld(0, 32'h00, 32'hA5A5A5A5, 1'b0);
        ld(0, 32'hFFC, 32'h0BADF00D, 1'b0);

        // LATENCY=0: request held high for four back-to-back services.
        st(1, 32'h0C, 32'hCAFEF00D, 2'b10, 1'b0);
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.dut = 1; e.data = 32'hCAFEF00D; e.flt = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        en[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h0C; size[1] = 2'b10;
        repeat (11) @(posedge clk);
        #1 en[1] = 1'b0;
        repeat (4) @(posedge clk);

        // LATENCY=3: store aborted by reset during WAIT must not commit.
        st(2, 32'h40, 32'h55555555, 2'b10, 1'b0);
        ld(2, 32'h40, 32'h55555555, 1'b0);
        @(posedge clk); #1;
        en[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h40; din[2] = 32'h12345678; size[2] = 2'b10;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        en[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b1;
        ld(2, 32'h40, 32'h55555555, 1'b0);

        repeat (3) @(posedge clk);
        tb_done = 1'b1;
    end
endmodule
